// File: rtl/sa_swap_cost_seq_if.sv
// Signal bundle between the swap-cost sequencer, neighbour memory, distance unit and annealing controller.
// Defining SA_TEMP_EN adds the temperature input used by the accept rule.
interface sa_swap_cost_seq_if #(
  parameter int NMAX   = 4,
  parameter int DIST_W = 10,
  parameter int ACC_W  = 12
);
  localparam int S     = 2 * NMAX;
  localparam int IDX_W = (S > 1) ? $clog2(S) : 1;

  // start and result are valid/ready channels: a transfer happens on the rising edge where
  // valid and ready are both high; the producer holds valid and payload steady until then.
  logic             start_valid;
  logic             start_ready;
  logic [7:0]       pa;
  logic [7:0]       pb;
`ifdef SA_TEMP_EN
  logic [ACC_W-1:0] temp;
`endif

  logic             nb_req;
  logic [IDX_W-1:0] nb_idx;
  logic [7:0]       nb_pos;
  logic             nb_v;

  logic [7:0]       opa0;
  logic [7:0]       opa1;
  logic [7:0]       opb0;
  logic [7:0]       opb1;
  logic             opav;
  logic             opbv;
  logic [DIST_W-1:0] da;
  logic [DIST_W-1:0] db;

  logic             busy;
  logic             result_valid;
  logic             result_ready;
  logic [ACC_W-1:0] cost_before;
  logic [ACC_W-1:0] cost_after;
  logic             accept;

`ifdef SA_TEMP_EN
  modport master (
    output start_valid, pa, pb, temp, nb_pos, nb_v, da, db, result_ready,
    input  start_ready, nb_req, nb_idx, opa0, opa1, opb0, opb1, opav, opbv,
           busy, result_valid, cost_before, cost_after, accept
  );

  modport slave (
    input  start_valid, pa, pb, temp, nb_pos, nb_v, da, db, result_ready,
    output start_ready, nb_req, nb_idx, opa0, opa1, opb0, opb1, opav, opbv,
           busy, result_valid, cost_before, cost_after, accept
  );
`else
  modport master (
    output start_valid, pa, pb, nb_pos, nb_v, da, db, result_ready,
    input  start_ready, nb_req, nb_idx, opa0, opa1, opb0, opb1, opav, opbv,
           busy, result_valid, cost_before, cost_after, accept
  );

  modport slave (
    input  start_valid, pa, pb, nb_pos, nb_v, da, db, result_ready,
    output start_ready, nb_req, nb_idx, opa0, opa1, opb0, opb1, opav, opbv,
           busy, result_valid, cost_before, cost_after, accept
  );
`endif
endinterface

// File: rtl/sa_swap_cost_seq.sv
// Swap-cost sequencer: walks both cells' neighbour slots, feeds the distance unit and sums before/after wire length.
// Optional SA_TEMP_EN: accept also when cost_after < cost_before + temp.
module sa_swap_cost_seq #(
  parameter int NMAX   = 4,
  parameter int DIST_W = 10,
  parameter int ACC_W  = 12
) (
  input  logic              clk,
  input  logic              rst_n,
  sa_swap_cost_seq_if.slave bus,
  output logic [1:0]        state_dbg
);
  localparam int S     = 2 * NMAX;
  localparam int IDX_W = (S > 1) ? $clog2(S) : 1;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    FETCH = 2'd1,
    DRAIN = 2'd2,
    DONE  = 2'd3
  } state_t;

  state_t           state;
  state_t           state_n;

  logic [7:0]       pa_r;
  logic [7:0]       pb_r;
  logic [IDX_W-1:0] cnt;
  logic             pending;
  logic [IDX_W-1:0] pend_idx;
  logic [ACC_W-1:0] acc_b;
  logic [ACC_W-1:0] acc_a;
  logic             accept_r;
`ifdef SA_TEMP_EN
  logic [ACC_W-1:0] temp_r;
`endif

  logic             start_fire;
  logic             cnt_last;
  logic             pend_is_a;
  logic [7:0]       self_pos;
  logic [7:0]       other_pos;
  logic             live;
  logic [DIST_W-1:0] da_in;
  logic [DIST_W-1:0] db_in;
  logic [ACC_W-1:0] acc_b_n;
  logic [ACC_W-1:0] acc_a_n;
  logic             accept_n;

  assign start_fire = bus.start_valid && (state == IDLE);
  assign cnt_last   = (cnt == IDX_W'(S - 1));
  assign pend_is_a  = (pend_idx < IDX_W'(NMAX));
  assign da_in      = bus.da;
  assign db_in      = bus.db;

  // ---------------- control FSM ----------------
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state <= IDLE;
    end else begin
      state <= state_n;
    end
  end

  always_comb begin
    state_n = state;
    case (state)
      IDLE:    if (bus.start_valid)  state_n = FETCH;
      FETCH:   if (cnt_last)         state_n = DRAIN;
      DRAIN:                         state_n = DONE;
      DONE:    if (bus.result_ready) state_n = IDLE;
      default:                       state_n = IDLE;
    endcase
  end

  assign state_dbg        = state;
  assign bus.start_ready  = (state == IDLE);
  assign bus.busy         = (state != IDLE);
  assign bus.nb_req       = (state == FETCH);
  assign bus.nb_idx       = (state == FETCH) ? cnt : '0;
  assign bus.result_valid = (state == DONE);

  // ---------------- data stage ----------------
  // The slot's own cell measures "before"; the partner cell measures "after", since after the
  // swap the neighbour connects to whichever cell now sits at the other position.
  always_comb begin
    self_pos  = pend_is_a ? pa_r : pb_r;
    other_pos = pend_is_a ? pb_r : pa_r;
    live      = pending && bus.nb_v && (bus.nb_pos != other_pos);

    bus.opa0  = 8'd0;
    bus.opa1  = 8'd0;
    bus.opb0  = 8'd0;
    bus.opb1  = 8'd0;
    if (pending) begin
      bus.opa0 = self_pos;
      bus.opa1 = bus.nb_pos;
      bus.opb0 = other_pos;
      bus.opb1 = bus.nb_pos;
    end
    bus.opav = live;
    bus.opbv = live;
  end

  always_comb begin
    acc_b_n = acc_b;
    acc_a_n = acc_a;
    if (live) begin
      acc_b_n = acc_b + ACC_W'(da_in);
      acc_a_n = acc_a + ACC_W'(db_in);
    end
`ifdef SA_TEMP_EN
    accept_n = ({1'b0, acc_a_n} < ({1'b0, acc_b_n} + {1'b0, temp_r}));
`else
    accept_n = (acc_a_n < acc_b_n);
`endif
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      pa_r     <= 8'd0;
      pb_r     <= 8'd0;
      cnt      <= '0;
      pending  <= 1'b0;
      pend_idx <= '0;
      acc_b    <= '0;
      acc_a    <= '0;
      accept_r <= 1'b0;
`ifdef SA_TEMP_EN
      temp_r   <= '0;
`endif
    end else begin
      pending  <= (state == FETCH);
      pend_idx <= cnt;
      if (start_fire) begin
        pa_r     <= bus.pa;
        pb_r     <= bus.pb;
        cnt      <= '0;
        acc_b    <= '0;
        acc_a    <= '0;
        accept_r <= 1'b0;
`ifdef SA_TEMP_EN
        temp_r   <= bus.temp;
`endif
      end else begin
        if (state == FETCH) begin
          cnt <= cnt_last ? '0 : cnt + 1'b1;
        end
        acc_b <= acc_b_n;
        acc_a <= acc_a_n;
        // DRAIN consumes the last slot, so the post-accumulation sums are final here.
        if (state == DRAIN) begin
          accept_r <= accept_n;
        end
      end
    end
  end

  assign bus.cost_before = acc_b;
  assign bus.cost_after  = acc_a;
  assign bus.accept      = accept_r;

endmodule

// File: tb/tb_sa_swap_cost_seq.sv
// Bench for sa_swap_cost_seq: Manhattan distance unit, registered neighbour memory, random swaps
// checked against a slot-list cost model. Build with SA_TEMP_EN to exercise the temperature rule.
module tb_sa_swap_cost_seq;
  localparam int NMAX   = 4;
  localparam int DIST_W = 10;
  localparam int ACC_W  = 12;
  localparam int S      = 2 * NMAX;

  logic       clk = 1'b0;
  logic       rst_n = 1'b0;
  logic [1:0] state_dbg;

  int n_cmp = 0;
  int n_err = 0;

  logic [7:0]       slot_pos [S];
  logic             slot_v   [S];
  logic [ACC_W-1:0] cur_temp = '0;

  sa_swap_cost_seq_if #(.NMAX(NMAX), .DIST_W(DIST_W), .ACC_W(ACC_W)) bus ();

  sa_swap_cost_seq #(.NMAX(NMAX), .DIST_W(DIST_W), .ACC_W(ACC_W)) dut (
    .clk       (clk),
    .rst_n     (rst_n),
    .bus       (bus),
    .state_dbg (state_dbg)
  );

  // ---------------- clock / reset ----------------
  always #5 clk = ~clk;

  // ---------------- environment models ----------------
  function automatic int manh(input logic [7:0] p, input logic [7:0] q);
    int dx;
    int dy;
    dx = int'(p[3:0]) - int'(q[3:0]);
    dy = int'(p[7:4]) - int'(q[7:4]);
    if (dx < 0) dx = -dx;
    if (dy < 0) dy = -dy;
    return dx + dy;
  endfunction

  always_comb begin
    bus.da = DIST_W'(manh(bus.opa0, bus.opa1));
    bus.db = DIST_W'(manh(bus.opb0, bus.opb1));
  end

  // Read data shows up one cycle after the request; idle cycles return junk flagged as occupied.
  always @(posedge clk) begin
    if (bus.nb_req) begin
      bus.nb_pos <= slot_pos[bus.nb_idx];
      bus.nb_v   <= slot_v[bus.nb_idx];
    end else begin
      bus.nb_pos <= 8'($urandom);
      bus.nb_v   <= 1'b1;
    end
  end

  // ---------------- scoreboard ----------------
  task automatic check_val(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_cmp++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  function automatic logic [7:0] rand_pos();
    logic [3:0] x;
    logic [3:0] y;
    x = 4'($urandom_range(0, 8));
    y = 4'($urandom_range(0, 8));
    return {y, x};
  endfunction

  function automatic logic [7:0] own_cell(input int s, input logic [7:0] a, input logic [7:0] b);
    return (s < NMAX) ? a : b;
  endfunction

  function automatic logic [7:0] partner_cell(input int s, input logic [7:0] a, input logic [7:0] b);
    return (s < NMAX) ? b : a;
  endfunction

  function automatic logic slot_counts(input int s, input logic [7:0] a, input logic [7:0] b);
    return slot_v[s] && (slot_pos[s] != partner_cell(s, a, b));
  endfunction

  // Wire length of every counted net with the cells in place, then with them exchanged.
  task automatic cost_model(input logic [7:0] a, input logic [7:0] b,
                            output int eb, output int ea, output logic eacc);
    int t;
    eb = 0;
    ea = 0;
    for (int s = 0; s < S; s++) begin
      if (slot_counts(s, a, b)) begin
        eb += manh(own_cell(s, a, b), slot_pos[s]);
        ea += manh(partner_cell(s, a, b), slot_pos[s]);
      end
    end
`ifdef SA_TEMP_EN
    t = int'(cur_temp);
`else
    t = 0;
`endif
    eacc = (ea < eb + t);
  endtask

  // ---------------- driver ----------------
  task automatic fill_one(input logic [7:0] p0);
    for (int s = 0; s < S; s++) begin
      slot_pos[s] = rand_pos();
      slot_v[s]   = 1'b0;
    end
    slot_pos[0] = p0;
    slot_v[0]   = 1'b1;
  endtask

  task automatic fill_rand(input logic [7:0] a, input logic [7:0] b);
    int r;
    for (int s = 0; s < S; s++) begin
      slot_v[s] = ($urandom_range(0, 3) != 0);
      r = $urandom_range(0, 5);
      if (r == 0)      slot_pos[s] = partner_cell(s, a, b);
      else if (r == 1) slot_pos[s] = own_cell(s, a, b);
      else             slot_pos[s] = rand_pos();
    end
  endtask

  // One swap request; abort_c > 0 pulses reset in that cycle instead of finishing.
  task automatic run_op(input logic [7:0] a, input logic [7:0] b, input int bp, input int abort_c);
    int   eb;
    int   ea;
    logic eacc;
    int   s;
    cost_model(a, b, eb, ea, eacc);

    @(negedge clk);
    bus.pa          = a;
    bus.pb          = b;
`ifdef SA_TEMP_EN
    bus.temp        = cur_temp;
`endif
    bus.start_valid = 1'b1;
    bus.result_ready = 1'b0;
    check_val("start_ready_idle", 32'(bus.start_ready), 32'd1);
    @(posedge clk);

    for (int c = 1; c <= S + 2; c++) begin
      @(negedge clk);
      if (c == 1) begin
        bus.start_valid = 1'b0;
        bus.pa = 8'($urandom);
        bus.pb = 8'($urandom);
      end
      if (c <= S + 1) begin
        check_val("nb_req", 32'(bus.nb_req), 32'(c <= S));
        if (c <= S) check_val("nb_idx", 32'(bus.nb_idx), 32'(c - 1));
        check_val("busy", 32'(bus.busy), 32'd1);
        check_val("result_valid_early", 32'(bus.result_valid), 32'd0);
        check_val("start_ready_busy", 32'(bus.start_ready), 32'd0);
        if (c >= 2) begin
          s = c - 2;
          check_val("opav", 32'(bus.opav), 32'(slot_counts(s, a, b)));
          check_val("opbv", 32'(bus.opbv), 32'(slot_counts(s, a, b)));
          if (slot_counts(s, a, b)) begin
            check_val("opa0", 32'(bus.opa0), 32'(own_cell(s, a, b)));
            check_val("opa1", 32'(bus.opa1), 32'(slot_pos[s]));
            check_val("opb0", 32'(bus.opb0), 32'(partner_cell(s, a, b)));
            check_val("opb1", 32'(bus.opb1), 32'(slot_pos[s]));
          end
        end
        if (c == abort_c) begin
          rst_n = 1'b0;
          #1;
          check_val("abort_nb_req", 32'(bus.nb_req), 32'd0);
          check_val("abort_busy", 32'(bus.busy), 32'd0);
          check_val("abort_result_valid", 32'(bus.result_valid), 32'd0);
          check_val("abort_start_ready", 32'(bus.start_ready), 32'd1);
          check_val("abort_cost_before", 32'(bus.cost_before), 32'd0);
          @(negedge clk);
          rst_n = 1'b1;
          return;
        end
        // result_ready while no result is offered must have no effect
        bus.result_ready = 1'($urandom_range(0, 1));
      end else begin
        check_val("result_valid", 32'(bus.result_valid), 32'd1);
        check_val("cost_before", 32'(bus.cost_before), 32'(eb));
        check_val("cost_after", 32'(bus.cost_after), 32'(ea));
        check_val("accept", 32'(bus.accept), 32'(eacc));
      end
    end

    for (int i = 0; i < bp; i++) begin
      bus.result_ready = 1'b0;
      bus.start_valid  = 1'($urandom_range(0, 1));
      @(negedge clk);
      check_val("hold_result_valid", 32'(bus.result_valid), 32'd1);
      check_val("hold_start_ready", 32'(bus.start_ready), 32'd0);
      check_val("hold_cost_before", 32'(bus.cost_before), 32'(eb));
      check_val("hold_cost_after", 32'(bus.cost_after), 32'(ea));
      check_val("hold_accept", 32'(bus.accept), 32'(eacc));
    end
    bus.start_valid  = 1'b0;
    bus.result_ready = 1'b1;
    @(negedge clk);
    bus.result_ready = 1'b0;
    check_val("post_result_valid", 32'(bus.result_valid), 32'd0);
    check_val("post_start_ready", 32'(bus.start_ready), 32'd1);
    check_val("post_busy", 32'(bus.busy), 32'd0);
  endtask

  // ---------------- stimulus ----------------
  initial begin
    logic [7:0] a;
    logic [7:0] b;
    bus.start_valid  = 1'b0;
    bus.result_ready = 1'b0;
    bus.pa           = 8'd0;
    bus.pb           = 8'd0;
`ifdef SA_TEMP_EN
    bus.temp         = '0;
`endif
    fill_one(8'h02);

    rst_n = 1'b0;
    repeat (3) @(negedge clk);
    check_val("rst_start_ready", 32'(bus.start_ready), 32'd1);
    check_val("rst_busy", 32'(bus.busy), 32'd0);
    check_val("rst_nb_req", 32'(bus.nb_req), 32'd0);
    check_val("rst_result_valid", 32'(bus.result_valid), 32'd0);
    check_val("rst_opav", 32'(bus.opav), 32'd0);
    check_val("rst_opa0", 32'(bus.opa0), 32'd0);
    check_val("rst_cost_before", 32'(bus.cost_before), 32'd0);
    check_val("rst_cost_after", 32'(bus.cost_after), 32'd0);
    check_val("rst_accept", 32'(bus.accept), 32'd0);
    rst_n = 1'b1;

    // Directed swaps around a = 0x00, b = 0x22
    cur_temp = ACC_W'(3);
    fill_one(8'h02);
    run_op(8'h00, 8'h22, 0, 0);
    cur_temp = '0;
    fill_one(8'h02);
    run_op(8'h00, 8'h22, 0, 0);
    fill_one(8'h33);
    run_op(8'h00, 8'h22, 1, 0);
    fill_one(8'h22);
    run_op(8'h00, 8'h22, 0, 0);

    // Every slot points at the far corner
    for (int s = 0; s < S; s++) begin
      slot_pos[s] = 8'h88;
      slot_v[s]   = 1'b1;
    end
    run_op(8'h00, 8'h88, 0, 0);

    // Result held off for five cycles
    fill_one(8'h33);
    run_op(8'h00, 8'h22, 5, 0);

    // Reset while slot 3 is being fetched, then a clean request
    fill_rand(8'h14, 8'h63);
    run_op(8'h14, 8'h63, 0, 4);
    fill_one(8'h33);
    run_op(8'h00, 8'h22, 0, 0);

    // Random swaps
    for (int n = 0; n < 40; n++) begin
      a = rand_pos();
      b = rand_pos();
      cur_temp = ACC_W'($urandom_range(0, 20));
      fill_rand(a, b);
      run_op(a, b, $urandom_range(0, 3), 0);
    end

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "timeout");
  end

endmodule

// File: doc/sa_swap_cost_seq.md
Name: sa_swap_cost_seq

Overview:
Sequencer for the simulated-annealing placer's swap-cost evaluation.
- For a proposed swap of cells A and B, fetches each cell's neighbour positions from neighbour memory, one slot per cycle.
- Drives the shared two-port 9x9 grid distance unit, accumulating wire length before and after the swap.
- Returns both costs and an accept flag to the annealing controller over a valid/ready result handshake.
- Position encoding: 8-bit {y[7:4], x[3:0]}, coordinates 0..8.

Parameters:
NMAX, 4, neighbour slots per cell; total slots S = 2*NMAX (A slots 0..NMAX-1, B slots NMAX..S-1)
DIST_W, 10, width of da/db from the distance unit
ACC_W, 12, accumulator/result width; must hold S*16

Ports:
clk  in  1  clock, all state on rising edge
rst_n  in  1  asynchronous active-low reset
start_valid  in  1  swap request valid
start_ready  out  1  high only in IDLE
pa  in  8  position of cell A, captured on start accept
pb  in  8  position of cell B, captured on start accept
nb_req  out  1  neighbour memory read strobe
nb_idx  out  clog2(S)  slot index being read
nb_pos  in  8  neighbour position, valid the cycle after nb_req
nb_v  in  1  slot occupied flag, same timing as nb_pos
opa0, opa1, opb0, opb1  out  8 each  distance unit operands
opav, opbv  out  1 each  distance unit operand-valid
da, db  in  DIST_W each  distance unit results (combinational, same cycle)
busy  out  1  high in FETCH, DRAIN, DONE
result_valid  out  1  result available
result_ready  in  1  result consumed
cost_before  out  ACC_W  sum of da over the operation
cost_after  out  ACC_W  sum of db over the operation
accept  out  1  swap accepted

Behaviour:
- Reset (async, rst_n low):
  - State IDLE.
  - All outputs 0 except start_ready=1.
  - Accumulators, slot counter and pending flag cleared.
  - Any in-flight operation is discarded; no partial result is ever presented.
- FSM transitions:
  - IDLE -> FETCH on start_valid && start_ready; capture pa/pb, clear both accumulators.
  - FETCH: nb_req=1, nb_idx = counter 0..S-1, one slot per cycle; after idx S-1 -> DRAIN.
  - DRAIN: one cycle, consumes the last returned slot -> DONE.
  - DONE: result_valid=1; cost_before, cost_after and accept held stable until result_ready; then -> IDLE.
- Data stage:
  - A registered pending flag marks that the previous cycle issued nb_req; it tracks the slot index.
  - When pending and the slot is an A slot: opa0=pa, opa1=nb_pos, opb0=pb, opb1=nb_pos.
  - When pending and the slot is a B slot: opa0=pb, opa1=nb_pos, opb0=pa, opb1=nb_pos.
  - opav = opbv = pending && nb_v && (nb_pos != position of the other swap cell). A net between A and B keeps its length, so it is skipped.
  - When not pending, all operands and valids are 0.
  - Accumulate on the clock edge: cost_before += da, cost_after += db. Both are zero-extended, with no saturation needed given ACC_W.
- Latency: accept edge at cycle 0; nb_req in cycles 1..S; data in cycles 2..S+1; result_valid first high in cycle S+2 (cycle 10 for NMAX=4).
- accept = (cost_after < cost_before), computed from the final accumulators and registered at DONE entry.
- start_valid outside IDLE is ignored; pa/pb changes after accept have no effect.
- result_ready while result_valid is low is ignored.

Optional Feature:
Macro SA_TEMP_EN.
- Defined: adds input temp [ACC_W-1:0], sampled on start accept; accept = (cost_after < cost_before + temp_reg), with the sum computed at ACC_W+1 bits so it cannot overflow.
- Undefined: no temp port; accept as above (strict improvement only).

Test Plan:
The bench instantiates a Manhattan model for the distance unit (d = |dx|+|dy|).
- pa=0x00, pb=0x22, slot0 nb_pos=0x02 nb_v=1, other slots nb_v=0 -> cost_before=2, cost_after=2, accept=0; result_valid in cycle 10.
- pa=0x00, pb=0x22, slot0 nb_pos=0x33 -> cost_before=6, cost_after=2, accept=1.
- pa=0x00, pb=0x22, slot0 nb_pos=0x22 (neighbour is B) -> opav=opbv=0 in that data cycle; costs 0/0, accept=0.
- pa=0x00, pb=0x88, all 8 slots nb_pos=0x88 valid except those equal to the other cell (A slots skipped) -> A slots contribute 0; B slots: before 0, after 16 each, so cost_before=0, cost_after=64, accept=0.
- Result backpressure: hold result_ready=0 for 5 cycles -> outputs stable, start_ready=0, start_valid ignored; after ready, return to IDLE and start_ready=1 the next cycle.
- Assert rst_n low during FETCH at nb_idx=3 -> nb_req, result_valid, busy go 0 immediately; after release, a new request produces correct costs. With SA_TEMP_EN and temp=3, case 1 (2 < 2+3) gives accept=1.
